// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM encoding, word geometry, halt marker.
package instruction_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

    localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instruction_loader_if #(
    parameter int unsigned ADDR_LENGTH = 32,
    parameter int unsigned DATA_LENGTH = 32
);
    logic [7:0]             i_rx_data;
    logic                   i_rx_valid;
    logic                   o_We;
    logic [ADDR_LENGTH-1:0] o_Addr;
    logic [DATA_LENGTH-1:0] o_Data;

    // master: the loader, which consumes bytes and drives the memory write port
    modport master (
        input  i_rx_data,
        input  i_rx_valid,
        output o_We,
        output o_Addr,
        output o_Data
    );

    modport slave (
        output i_rx_data,
        output i_rx_valid,
        input  o_We,
        input  o_Addr,
        input  o_Data
    );
endinterface

// File: rtl/word_assembler.sv
// Packs bytes MSB-first into a word; word_valid is a combinational strobe on the last byte.
module word_assembler
    import instruction_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_byte_en,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam logic [BYTE_CNT_W-1:0] LastByte = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [BYTE_CNT_W-1:0] cnt_q;
    logic [WORD_W-9:0]     shift_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (i_byte_en) begin
            cnt_q   <= cnt_q + 1'b1;
            shift_q <= {shift_q[WORD_W-17:0], i_byte};
        end
    end

    // The final byte is merged directly so the word is ready on the edge that samples it
    assign word       = {shift_q, i_byte};
    assign word_valid = i_byte_en && (cnt_q == LastByte);

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from a UART byte stream into instruction memory, stopping on halt or overflow.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned       MEM_SIZE    = 5,
    parameter int unsigned       ADDR_LENGTH = 32,
    parameter int unsigned       DATA_LENGTH = 32,
    parameter logic [WORD_W-1:0] HALT_WORD   = DEFAULT_HALT_WORD
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    instruction_loader_if.master   bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overflow,
    output logic [ADDR_LENGTH-1:0] o_word_count
);

    localparam logic [ADDR_LENGTH-1:0] MemSize = ADDR_LENGTH'(MEM_SIZE);

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0] data_q, data_d;
    logic [ADDR_LENGTH-1:0] wptr_q, wptr_d;

    logic              byte_en;
    logic [WORD_W-1:0] word;
    logic              word_valid;

    // A start pulse drops any byte arriving in the same cycle
    assign byte_en = (state_q == StLoad) && bus.i_rx_valid && !i_start;

    word_assembler u_word_assembler (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (i_start),
        .i_byte_en  (byte_en),
        .i_byte     (bus.i_rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        wptr_d  = wptr_q;
        if (i_start) begin
            state_d = StLoad;
            wptr_d  = '0;
        end else if (word_valid) begin
            if (wptr_q < MemSize) begin
                we_d   = 1'b1;
                addr_d = wptr_q;
                data_d = DATA_LENGTH'(word);
                wptr_d = wptr_q + 1'b1;
                if (word == HALT_WORD) begin
                    state_d = StDone;
                end
            end else begin
                state_d = StErr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wptr_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wptr_q  <= wptr_d;
        end
    end

    assign bus.o_We     = we_q;
    assign bus.o_Addr   = addr_q;
    assign bus.o_Data   = data_q;
    assign o_busy       = (state_q == StLoad);
    assign o_done       = (state_q == StDone);
    assign o_overflow   = (state_q == StErr);
    assign o_word_count = wptr_q;

endmodule
